// File: rtl/dm_pkg.sv
// dm_pkg: shared types and constants for the dm_responder data-memory block.
//   state_t        : responder FSM states (IDLE, WAIT, RESP)
//   BYTES_PER_WORD : bytes moved per word access
//   WAIT_W         : width of the wait-state counter (covers 0..15)
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WAIT_W         = 4;

endpackage

// File: rtl/dm_byte_ram.sv
// dm_byte_ram: 2**ADDR_W x 8 byte array with one word-wide port.
//   clk       in  : rising-edge clock
//   rst_n     in  : async active-low reset (clears the read register only)
//   we        in  : write the addressed word, big-endian
//   re        in  : capture the addressed word into rdata
//   clr       in  : load rdata with zero (write / error responses)
//   word_addr in  : word index (byte address without the two LSBs)
//   wdata     in  : write data, wdata[31:24] lands at the lowest byte address
//   rdata     out : registered read data, holds until the next re/clr
module dm_byte_ram
  import dm_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [ADDR_W-3:0] word_addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [7:0] mem [DEPTH];

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        mem[{word_addr, b[1:0]}] <= wdata[31-8*b -: 8];
      end
    end
  end

  // Read register doubles as the response data register, so it holds between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'h0000_0000;
    end else if (re) begin
      rdata <= {mem[{word_addr, 2'd0}], mem[{word_addr, 2'd1}],
                mem[{word_addr, 2'd2}], mem[{word_addr, 2'd3}]};
    end else if (clr) begin
      rdata <= 32'h0000_0000;
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: valid/ready data-memory responder with WAIT_CYCLES wait states.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : request handshake (one outstanding request)
//   req_write             : 1 = word write, 0 = word read
//   req_addr, req_wdata   : byte address, write data
//   rsp_valid             : one-cycle response strobe
//   rsp_rdata, rsp_err    : response payload, held until the next response
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // Misaligned or any bit above the decoded range is an error.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (|a[31:ADDR_W]);
  endfunction

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] cnt;
  logic              lat_write, lat_err;
  logic [ADDR_W-3:0] lat_word;
  logic [31:0]       lat_wdata;

  logic              accept, exec;
  logic              op_write, op_err;
  logic [ADDR_W-3:0] op_word;
  logic [31:0]       op_wdata;

  assign accept = req_valid && req_ready;

  // Access operands: with zero wait states the access runs at the acceptance
  // edge, so the live request is used while in IDLE.
  always_comb begin
    if (state == IDLE) begin
      op_write = req_write;
      op_err   = addr_err(req_addr);
      op_word  = req_addr[ADDR_W-1:2];
      op_wdata = req_wdata;
    end else begin
      op_write = lat_write;
      op_err   = lat_err;
      op_word  = lat_word;
      op_wdata = lat_wdata;
    end
  end

  // Next state and the "access executes at this edge" strobe.
  always_comb begin
    state_nxt = state;
    exec      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          exec      = (WAIT_CYCLES == 0);
          state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == WAIT_W'(1)) begin
          exec      = 1'b1;
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, handshake outputs and response flag; outputs are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      rsp_err   <= exec ? op_err : rsp_err;
    end
  end

  // Request latch and wait-state counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= {WAIT_W{1'b0}};
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_word  <= {(ADDR_W-2){1'b0}};
      lat_wdata <= 32'h0000_0000;
    end else if (accept) begin
      cnt       <= WAIT_W'(WAIT_CYCLES);
      lat_write <= req_write;
      lat_err   <= addr_err(req_addr);
      lat_word  <= req_addr[ADDR_W-1:2];
      lat_wdata <= req_wdata;
    end else if (state == WAIT) begin
      cnt       <= cnt - WAIT_W'(1);
    end else begin
      cnt       <= cnt;
    end
  end

  // Writes and errors clear the read register so rsp_rdata reads 0 for them.
  dm_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (exec && op_write && !op_err),
    .re        (exec && !op_write && !op_err),
    .clr       (exec && (op_write || op_err)),
    .word_addr (op_word),
    .wdata     (op_wdata),
    .rdata     (rsp_rdata)
  );

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed, table-driven bench for dm_responder.
// u_dut runs with WAIT_CYCLES=2, u_dut0 with WAIT_CYCLES=0 for the back-to-back handshake.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        h_valid, h_ready, h_write, h_rsp_valid, h_rsp_err;
  logic [31:0] h_addr, h_wdata, h_rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dm_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(h_valid), .req_ready(h_ready),
    .req_write(h_write), .req_addr(h_addr), .req_wdata(h_wdata),
    .rsp_valid(h_rsp_valid), .rsp_rdata(h_rsp_rdata), .rsp_err(h_rsp_err));

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One request on u_dut; returns response payload and latency in cycles after acceptance.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat);
    bit got;
    @(negedge clk);
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0; lat = 99; rd = 32'hxxxx_xxxx; er = 1'bx;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (k > 1) @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1; lat = k; rd = rsp_rdata; er = rsp_err;
      end
    end
  endtask

  // Four back-to-back requests on u_dut0 with req_valid held high throughout.
  task automatic hs_burst(input logic wr, input logic [31:0] base, input logic [31:0] exp_data [4]);
    int acc, rsp, last_acc;
    acc = 0; rsp = 0; last_acc = -10;
    for (int cyc = 0; cyc < 40 && rsp < 4; cyc++) begin
      @(negedge clk);
      if (h_rsp_valid) begin
        check("hs_ready_low_in_resp", {31'd0, h_ready}, 32'd0);
        check($sformatf("hs_rdata_%0d", rsp), h_rsp_rdata, wr ? 32'd0 : exp_data[rsp]);
        rsp++;
      end
      if (h_ready) begin
        if (acc < 4) begin
          if (acc > 0) check("hs_accept_spacing", cyc - last_acc, 32'd2);
          last_acc = cyc;
          h_valid = 1'b1; h_write = wr; h_addr = base + 32'(4 * acc); h_wdata = exp_data[acc];
          acc++;
        end else begin
          h_valid = 1'b0;
        end
      end
    end
    h_valid = 1'b0;
    check("hs_accept_count", acc, 32'd4);
    check("hs_resp_count", rsp, 32'd4);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] hs_data [4];

  initial begin
    // preload words used by later checks, then the main sequences
    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0044, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0040, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0040, 32'h0000_0000, 32'hAABB_CCDD, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0044, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0022, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    h_valid = 1'b0; h_write = 1'b0; h_addr = 32'd0; h_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd3);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
    end

    check("byte_0x40", {24'd0, u_dut.u_ram.mem[8'h40]}, 32'h0000_00AA);
    check("byte_0x41", {24'd0, u_dut.u_ram.mem[8'h41]}, 32'h0000_00BB);
    check("byte_0x42", {24'd0, u_dut.u_ram.mem[8'h42]}, 32'h0000_00CC);
    check("byte_0x43", {24'd0, u_dut.u_ram.mem[8'h43]}, 32'h0000_00DD);

    // reset in the middle of a write's wait states drops the write
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 32'h10, 32'd0, rd, er, lat);
    check("midrst_read_0x10", rd, 32'd0);
    check("midrst_read_lat", lat, 32'd3);

    // idle hold after a read of 0x12345678
    do_req(1'b0, 32'h20, 32'd0, rd, er, lat);
    check("hold_read_0x20", rd, 32'h1234_5678);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("hold_valid_c%0d", c), {31'd0, rsp_valid}, 32'd0);
      check($sformatf("hold_rdata_c%0d", c), rsp_rdata, 32'h1234_5678);
    end

    // back-to-back handshake, zero wait states
    hs_data[0] = 32'h0102_0304; hs_data[1] = 32'h1122_3344;
    hs_data[2] = 32'h5566_7788; hs_data[3] = 32'h99AA_BBCC;
    hs_burst(1'b1, 32'h80, hs_data);
    repeat (2) @(negedge clk);
    hs_burst(1'b0, 32'h80, hs_data);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
